bcd2bin: RTL and testbench
==========================

// Module: bcd2bin
// PURPOSE
//  Sequential BCD-to-binary converter; inverse of the bin2bcd block.
//  Takes four packed BCD digits on a start pulse and produces an N-bit unsigned binary value.
//  Works by iterative multiply-by-10-and-add, one digit per clock, MSD first.
//  Sits between keypad/display-side BCD logic and binary datapath logic; start/done handshake matches bin2bcd.
// PARAMETERS
//  N  7  width of binary result; values above 2**N-1 flag ovf
// PORTS
//  clk        in   1  single clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  request conversion; sampled only when not busy
//  bcd3       in   4  thousands digit (MSD)
//  bcd2       in   4  hundreds digit
//  bcd1       in   4  tens digit
//  bcd0       in   4  units digit (LSD)
//  bin        out  N  binary result, registered, valid while done=1
//  done       out  1  level; high from result until next accepted start
//  busy       out  1  high while conversion in progress
//  err_digit  out  1  some input nibble was >9; valid with done
//  ovf        out  1  decimal value > 2**N-1; valid with done
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state IDLE; bin=0, done=0, busy=0, err_digit=0, ovf=0.
//    Reset wins over start and aborts any conversion in progress; no partial result appears.
//  - FSM states: IDLE, CONV, DONE.
//  - IDLE/DONE + start=1 at edge E0:
//    - capture bcd3..bcd0 into an internal register;
//    - acc=0, idx=3, state=CONV, busy=1, done=0.
//    - bin/err_digit/ovf keep their old values until the new result.
//  - CONV, one digit per edge (edges E1..E4):
//    - acc <= acc*10 + digit[idx]; implement *10 as (acc<<3)+(acc<<1), no multiplier;
//    - idx decrements;
//    - if the digit is >9, set an internal err flag.
//  - Accumulator width: 14 bits (max 9999), independent of N.
//  - Edge E4 (last digit) registers outputs, state=DONE, busy=0, done=1.
//    - Latency: done rises 4 cycles after the start-sampling edge.
//  - Result rules, evaluated in this order:
//    - err: err_digit=1, ovf=0, bin=0;
//    - else acc > 2**N-1: ovf=1, bin=acc[N-1:0] (truncated);
//    - else bin=acc, both flags 0.
//  - start while busy=1 is ignored. Inputs are not re-sampled; the captured digits are used.
//  - DONE holds all outputs stable indefinitely; start in DONE behaves as in IDLE (back-to-back allowed).
//  - Input digits may change freely after E0 without affecting the result.
//  - done and busy are never high together.
// TESTING
//  - Reset: hold rst 3 cycles -> bin=0, done=0, busy=0, err_digit=0, ovf=0.
//  - digits 0,0,5,7 + start -> busy for 4 cycles; done=1 exactly 4 cycles after start edge; bin=57, flags 0.
//  - Directed sweep 0, 99, 127 (N=7) -> bin equals value, ovf=0. Also 0128 -> ovf=1, bin=0; 9999 -> ovf=1, bin=9999 mod 128=15.
//  - digits 0,0,A,5 -> err_digit=1, bin=0, ovf=0. Next start with 0,0,4,2 -> err_digit=0, bin=42.
//  - Start 0057, change digits to 0099 and pulse start again during busy -> result still 57, one done only.
//  - Start 0099, assert rst at cycle 2 -> outputs 0 next edge, IDLE. New start 0012 -> bin=12 after 4 cycles.

Source files
------------

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - sequential four-digit BCD to N-bit binary converter
// Consumes one captured digit per clock, MSD first, via acc*10 + digit.
module bcd2bin #(
   parameter int N = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   bcd3,
   input  logic [3:0]   bcd2,
   input  logic [3:0]   bcd1,
   input  logic [3:0]   bcd0,
   output logic [N-1:0] bin,
   output logic         done,
   output logic         busy,
   output logic         err_digit,
   output logic         ovf
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [31:0] MAX_VAL = (32'd1 << N) - 32'd1;

   logic [1:0]  state;
   logic [15:0] digits;
   logic [13:0] acc;
   logic [1:0]  idx;
   logic        err;

   logic [3:0]  digit;
   logic [13:0] acc_next;
   logic        digit_bad;
   logic        too_big;

   // Non-BCD nibbles may wrap the 14-bit accumulator; the err flag masks that result.
   always_comb begin
      digit     = digits[{idx, 2'b00} +: 4];
      acc_next  = (acc << 3) + (acc << 1) + {10'd0, digit};
      digit_bad = digit > 4'd9;
      too_big   = 32'(acc_next) > MAX_VAL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         digits    <= '0;
         acc       <= '0;
         idx       <= '0;
         err       <= 1'b0;
         bin       <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         err_digit <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  digits <= {bcd3, bcd2, bcd1, bcd0};
                  acc    <= '0;
                  idx    <= 2'd3;
                  err    <= 1'b0;
                  state  <= CONV;
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end
            end
            CONV: begin
               acc <= acc_next;
               idx <= idx - 2'd1;
               err <= err | digit_bad;
               if (idx == 2'd0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (err | digit_bad) begin
                     err_digit <= 1'b1;
                     ovf       <= 1'b0;
                     bin       <= '0;
                  end else begin
                     err_digit <= 1'b0;
                     ovf       <= too_big;
                     bin       <= N'(acc_next);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - self-checking bench for bcd2bin
// Directed cases plus random digits against an arithmetic reference model.
module tb_bcd2bin;

   localparam int N = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   bcd3, bcd2, bcd1, bcd0;
   logic [N-1:0] bin;
   logic         done, busy, err_digit, ovf;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] prev_bin = '0;

   always #5 clk = ~clk;

   bcd2bin #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
      .bin(bin), .done(done), .busy(busy), .err_digit(err_digit), .ovf(ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_bin"}, 32'(bin), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_err"}, 32'(err_digit), 0);
      check({tag, "_ovf"}, 32'(ovf), 0);
   endtask

   // glitch: pulse start with different digits one cycle into the conversion
   task automatic convert(input logic [3:0] d3, d2, d1, d0, input bit glitch);
      int value;
      bit exp_err, exp_ovf;
      logic [N-1:0] exp_bin;
      value = int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
      if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) begin
         exp_err = 1; exp_ovf = 0; exp_bin = '0;
      end else if (value > (2 ** N) - 1) begin
         exp_err = 0; exp_ovf = 1; exp_bin = N'(value % (2 ** N));
      end else begin
         exp_err = 0; exp_ovf = 0; exp_bin = N'(value);
      end
      @(negedge clk);
      bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0; start = 1'b1;
      @(posedge clk); #1;
      check("e0_busy", 32'(busy), 1);
      check("e0_done", 32'(done), 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (glitch && c == 1) begin
            bcd3 = 0; bcd2 = 0; bcd1 = 9; bcd0 = 9; start = 1'b1;
         end else begin
            start = 1'b0;
            bcd3 = 4'($urandom); bcd2 = 4'($urandom); bcd1 = 4'($urandom); bcd0 = 4'($urandom);
         end
         @(posedge clk); #1;
         if (c < 4) begin
            check("conv_busy", 32'(busy), 1);
            check("conv_done", 32'(done), 0);
            check("conv_bin_held", 32'(bin), 32'(prev_bin));
         end else begin
            check("res_done", 32'(done), 1);
            check("res_busy", 32'(busy), 0);
            check("res_bin", 32'(bin), 32'(exp_bin));
            check("res_err", 32'(err_digit), 32'(exp_err));
            check("res_ovf", 32'(ovf), 32'(exp_ovf));
         end
      end
      start = 1'b0;
      prev_bin = exp_bin;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      bcd3 = 0; bcd2 = 0; bcd1 = 0; bcd0 = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      convert(0, 0, 5, 7, 0);
      // outputs hold in DONE
      repeat (3) @(posedge clk);
      #1;
      check("hold_done", 32'(done), 1);
      check("hold_busy", 32'(busy), 0);
      check("hold_bin", 32'(bin), 57);

      convert(0, 0, 0, 0, 0);
      convert(0, 0, 9, 9, 0);
      convert(0, 1, 2, 7, 0);
      convert(0, 1, 2, 8, 0);
      convert(9, 9, 9, 9, 0);
      convert(0, 0, 4'hA, 5, 0);
      convert(0, 0, 4, 2, 0);
      convert(0, 0, 5, 7, 1);

      // reset aborts a conversion with no partial result
      @(negedge clk);
      bcd3 = 0; bcd2 = 0; bcd1 = 9; bcd0 = 9; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 0);
      check("abort_no_busy", 32'(busy), 0);
      prev_bin = '0;
      convert(0, 0, 1, 2, 0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0)
            convert(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0);
         else
            convert(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
